axi_wfifo_reader: RTL

Read-side engine for the write-data FIFO in the AXI FIFO BFM. It pops 128-bit beats from the FIFO read port (`rd_en`/`rd_data`/`empty`) and presents them as an AXI4 W-channel burst (`wvalid`/`wready`/`wdata`/`wstrb`/`wlast`). It is the consumer paired with the FIFO driver that fills the FIFO through `wr_en`/`wr_data`. A 2-entry output buffer hides the 1-cycle FIFO read latency, so it can sustain one beat per cycle.

---
 rtl/axi_wfifo_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axi_wfifo_reader.sv
// axi_wfifo_reader: drains the write-data FIFO and drives an AXI4 W-channel
// burst. A two-slot output buffer absorbs the one-cycle FIFO read latency
// so beats can stream back-to-back.
module axi_wfifo_reader #(
  parameter int DATA_W = 128,
  parameter int STRB_W = DATA_W / 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  awlen,
  output logic              busy,
  output logic              done,
  input  logic              empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_next;

  logic [LEN_W:0]  total;
  logic [LEN_W:0]  req_cnt;
  logic [LEN_W:0]  sent_cnt;
  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic [1:0]      occ;
  logic            inflight;
  logic            done_q;

  logic            pop;
  logic            last_beat;
  logic            start_ok;
  logic            finish;
  logic [2:0]      pending;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept a start in IDLE, leave ACTIVE on the last handshake.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pop && last_beat) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake, read-issue and W-channel outputs.
  always_comb begin
    wvalid    = (occ != 2'd0);
    pop       = wvalid & wready;
    last_beat = (sent_cnt == (total - CNT_ONE));
    // Slots that will be committed after this edge: buffered plus the read
    // landing now, minus the beat leaving now. Issue only if one stays free.
    pending   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    rd_en     = (state == ACTIVE) & ~empty & (req_cnt < total) & (pending < 3'd2);
    busy      = (state == ACTIVE);
    done      = done_q;
    wdata     = slot0;
    wstrb     = wvalid ? '1 : '0;
    wlast     = wvalid & last_beat;
  end

  // Datapath: burst length, counters, read pipeline and the output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      total    <= '0;
      req_cnt  <= '0;
      sent_cnt <= '0;
      slot0    <= '0;
      slot1    <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= rd_en;
      done_q   <= finish;
      if (start_ok) begin
        total    <= {1'b0, awlen} + CNT_ONE;
        req_cnt  <= '0;
        sent_cnt <= '0;
        slot0    <= '0;
        slot1    <= '0;
        occ      <= '0;
      end else begin
        if (rd_en) begin
          req_cnt <= req_cnt + CNT_ONE;
        end
        if (pop) begin
          sent_cnt <= sent_cnt + CNT_ONE;
        end
        // Slots above the occupancy are kept at zero so wdata reads zero
        // whenever wvalid is low.
        case ({inflight, pop})
          2'b10: begin
            if (occ == 2'd0) begin
              slot0 <= rd_data;
            end else begin
              slot1 <= rd_data;
            end
            occ <= occ + 2'd1;
          end
          2'b01: begin
            slot0 <= slot1;
            slot1 <= '0;
            occ   <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              slot0 <= rd_data;
            end else begin
              slot0 <= slot1;
              slot1 <= rd_data;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
